// File: rtl/framebuffer_pkg.sv
// Shared definitions for the framebuffer read and write paths: lane geometry
// helpers, the accumulator operation encoding and pixel-mask to byte-strobe expansion.
package framebuffer_pkg;

  localparam int MAX_LANES = 64;
  localparam int MAX_STRB  = 256;

  typedef enum logic [2:0] {
    ACC_HOLD,
    ACC_LOAD,
    ACC_MERGE,
    ACC_FLUSH_LOAD,
    ACC_FLUSH
  } accOp_e;

  function automatic int calcLanes(input int streamWidth, input int pixelWidth);
    return streamWidth / pixelWidth;
  endfunction

  // LANES is expected to be a power of two and at least 2.
  function automatic int calcTagPos(input int lanes);
    return $clog2(lanes);
  endfunction

  // Each set pixel bit becomes bytesPerPixel consecutive byte enables, lane 0 lowest.
  function automatic logic [MAX_STRB-1:0] maskToStrb(input logic [MAX_LANES-1:0] mask,
                                                     input int bytesPerPixel);
    logic [MAX_STRB-1:0] strb;
    logic [MAX_STRB-1:0] laneOnes;
    strb     = '0;
    laneOnes = (MAX_STRB'(1) << bytesPerPixel) - MAX_STRB'(1);
    for (int l = MAX_LANES - 1; l >= 0; l--) begin
      strb = strb << bytesPerPixel;
      if (mask[l]) begin
        strb = strb | laneOnes;
      end
    end
    return strb;
  endfunction

endpackage

// File: rtl/framebuffer_deserializer.sv
// Packs a per-pixel fragment stream into masked memory-word beats, one beat per
// run of consecutive pixels that land in the same word.
module framebuffer_deserializer
  import framebuffer_pkg::*;
#(
  parameter int STREAM_WIDTH = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int PIXEL_WIDTH  = 16,
  localparam int LANES       = calcLanes(STREAM_WIDTH, PIXEL_WIDTH),
  localparam int TAG_POS     = calcTagPos(LANES),
  localparam int STRB_W      = STREAM_WIDTH / 8,
  localparam int TAG_W       = ADDR_WIDTH - TAG_POS
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_frag_axis_tvalid,
  output logic                    s_frag_axis_tready,
  input  logic [PIXEL_WIDTH-1:0]  s_frag_axis_tdata,
  input  logic [ADDR_WIDTH-1:0]   s_frag_axis_tdest,
  input  logic                    s_frag_axis_tstrb,
  input  logic                    s_frag_axis_tlast,
  output logic                    m_mem_axi_wvalid,
  input  logic                    m_mem_axi_wready,
  output logic [STREAM_WIDTH-1:0] m_mem_axi_wdata,
  output logic [STRB_W-1:0]       m_mem_axi_wstrb,
  output logic                    m_mem_axi_wlast,
  output logic [TAG_W-1:0]        m_mem_waddr
);

  localparam int BYTES_PER_PIXEL = PIXEL_WIDTH / 8;

  logic                    accValid_q, accValid_d;
  logic [TAG_W-1:0]        accTag_q, accTag_d;
  logic [STREAM_WIDTH-1:0] accData_q, accData_d;
  logic [LANES-1:0]        accMask_q, accMask_d;
  logic                    accClosed_q, accClosed_d;
  logic                    accLast_q, accLast_d;

  logic                    wvalid_q, wvalid_d;
  logic [STREAM_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    wlast_q, wlast_d;
  logic [TAG_W-1:0]        waddr_q, waddr_d;

  logic [TAG_W-1:0]        fragTag;
  logic [TAG_POS-1:0]      fragLane;
  logic                    outFree;
  logic                    sameWord;
  logic                    accept;
  logic                    flush;
  logic                    keepBeat;
  logic [STRB_W-1:0]       flushStrb;
  accOp_e                  accOp;

  assign fragTag  = s_frag_axis_tdest[ADDR_WIDTH-1:TAG_POS];
  assign fragLane = s_frag_axis_tdest[TAG_POS-1:0];

  assign outFree  = !wvalid_q || m_mem_axi_wready;
  assign sameWord = accValid_q && !accClosed_q && (fragTag == accTag_q);
  assign accept   = s_frag_axis_tvalid && s_frag_axis_tready;

  // A pixel that would displace the accumulator can only enter when the output slot is free.
  assign s_frag_axis_tready = !accValid_q || sameWord || outFree;

  always_comb begin
    accOp = ACC_HOLD;
    if (accept) begin
      if (!accValid_q) begin
        accOp = ACC_LOAD;
      end else if (sameWord) begin
        accOp = ACC_MERGE;
      end else begin
        accOp = ACC_FLUSH_LOAD;
      end
    end else if (accValid_q && accClosed_q && outFree) begin
      accOp = ACC_FLUSH;
    end
  end

  assign flush     = (accOp == ACC_FLUSH_LOAD) || (accOp == ACC_FLUSH);
  assign keepBeat  = (accMask_q != '0) || accLast_q;
  assign flushStrb = STRB_W'(maskToStrb(MAX_LANES'(accMask_q), BYTES_PER_PIXEL));

  always_comb begin
    accValid_d  = accValid_q;
    accTag_d    = accTag_q;
    accData_d   = accData_q;
    accMask_d   = accMask_q;
    accClosed_d = accClosed_q;
    accLast_d   = accLast_q;
    case (accOp)
      ACC_LOAD, ACC_FLUSH_LOAD: begin
        accValid_d  = 1'b1;
        accTag_d    = fragTag;
        accData_d   = '0;
        accMask_d   = '0;
        accClosed_d = s_frag_axis_tlast;
        accLast_d   = s_frag_axis_tlast;
      end
      ACC_MERGE: begin
        accClosed_d = s_frag_axis_tlast;
        accLast_d   = s_frag_axis_tlast;
      end
      ACC_FLUSH: begin
        accValid_d  = 1'b0;
        accMask_d   = '0;
        accClosed_d = 1'b0;
        accLast_d   = 1'b0;
      end
      default: begin
      end
    endcase
    // Lane write lands on top of a fresh load or an ongoing merge alike.
    if (accept && s_frag_axis_tstrb) begin
      for (int l = 0; l < LANES; l++) begin
        if (fragLane == TAG_POS'(l)) begin
          accData_d[l*PIXEL_WIDTH +: PIXEL_WIDTH] = s_frag_axis_tdata;
          accMask_d[l] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      accValid_q  <= 1'b0;
      accTag_q    <= '0;
      accData_q   <= '0;
      accMask_q   <= '0;
      accClosed_q <= 1'b0;
      accLast_q   <= 1'b0;
    end else begin
      accValid_q  <= accValid_d;
      accTag_q    <= accTag_d;
      accData_q   <= accData_d;
      accMask_q   <= accMask_d;
      accClosed_q <= accClosed_d;
      accLast_q   <= accLast_d;
    end
  end

  // Empty words vanish, except an end-of-stream word which goes out with no strobes.
  always_comb begin
    wvalid_d = wvalid_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wlast_d  = wlast_q;
    waddr_d  = waddr_q;
    if (outFree) begin
      wvalid_d = 1'b0;
      if (flush && keepBeat) begin
        wvalid_d = 1'b1;
        wdata_d  = accData_q;
        wstrb_d  = flushStrb;
        wlast_d  = accLast_q;
        waddr_d  = accTag_q;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wlast_q  <= 1'b0;
      waddr_q  <= '0;
    end else begin
      wvalid_q <= wvalid_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wlast_q  <= wlast_d;
      waddr_q  <= waddr_d;
    end
  end

  assign m_mem_axi_wvalid = wvalid_q;
  assign m_mem_axi_wdata  = wdata_q;
  assign m_mem_axi_wstrb  = wstrb_q;
  assign m_mem_axi_wlast  = wlast_q;
  assign m_mem_waddr      = waddr_q;

endmodule

// File: tb/tb_framebuffer_deserializer.sv
// Directed bench for framebuffer_deserializer: a word-grouping model predicts
// every memory beat, plus literal checks on timing and beat contents.
module tb_framebuffer_deserializer;

  localparam int SW   = 32;
  localparam int AW   = 32;
  localparam int PW   = 16;
  localparam int TAGW = 31;

  logic            clock = 1'b0;
  logic            reset;
  logic            tvalid;
  logic            tready;
  logic [PW-1:0]   tdata;
  logic [AW-1:0]   tdest;
  logic            tstrb;
  logic            tlast;
  logic            wvalid;
  logic            wready;
  logic [SW-1:0]   wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic [TAGW-1:0] waddr;

  typedef struct {
    logic [TAGW-1:0] addr;
    logic [SW-1:0]   data;
    logic [3:0]      strb;
    logic            last;
  } beat_t;

  int    checks = 0;
  int    failures = 0;
  beat_t expQ[$];
  int    beatCount = 0;
  beat_t lastBeat;
  int    lastWaited;
  int    waitedArr[6];

  bit              mValid;
  logic [TAGW-1:0] mTag;
  logic [PW-1:0]   mPix[2];
  bit              mWritten[2];

  bit    prevStall;
  beat_t prevOut;

  always #5 clock = ~clock;

  framebuffer_deserializer #(
    .STREAM_WIDTH(SW),
    .ADDR_WIDTH(AW),
    .PIXEL_WIDTH(PW)
  ) dut (
    .aclk(clock),
    .areset(reset),
    .s_frag_axis_tvalid(tvalid),
    .s_frag_axis_tready(tready),
    .s_frag_axis_tdata(tdata),
    .s_frag_axis_tdest(tdest),
    .s_frag_axis_tstrb(tstrb),
    .s_frag_axis_tlast(tlast),
    .m_mem_axi_wvalid(wvalid),
    .m_mem_axi_wready(wready),
    .m_mem_axi_wdata(wdata),
    .m_mem_axi_wstrb(wstrb),
    .m_mem_axi_wlast(wlast),
    .m_mem_waddr(waddr)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // The word being built closes on a change of word or on tlast; it becomes a
  // beat if any pixel in it was written or it ends the stream.
  function automatic void modelEmit(input bit last);
    beat_t b;
    b.addr = mTag;
    b.data = {mPix[1], mPix[0]};
    b.strb = {{2{mWritten[1]}}, {2{mWritten[0]}}};
    b.last = last;
    if (b.strb != 4'h0 || last) expQ.push_back(b);
    mValid = 0;
  endfunction

  function automatic void modelPush(input logic [AW-1:0] addr, input logic [PW-1:0] data,
                                    input bit strb, input bit last);
    logic [TAGW-1:0] tag;
    int lane;
    tag  = addr[AW-1:1];
    lane = int'(addr[0]);
    if (mValid && tag != mTag) modelEmit(1'b0);
    if (!mValid) begin
      mValid      = 1;
      mTag        = tag;
      mPix[0]     = '0;
      mPix[1]     = '0;
      mWritten[0] = 0;
      mWritten[1] = 0;
    end
    if (strb) begin
      mPix[lane]     = data;
      mWritten[lane] = 1;
    end
    if (last) modelEmit(1'b1);
  endfunction

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [PW-1:0] data,
                               input bit strb, input bit last);
    int waited = 0;
    bit done = 0;
    @(negedge clock);
    tvalid = 1'b1;
    tdest  = addr;
    tdata  = data;
    tstrb  = strb;
    tlast  = last;
    while (!done) begin
      #4;
      if (tready === 1'b1) begin
        modelPush(addr, data, strb, last);
        done = 1;
      end else if (waited >= 50) begin
        checkOutput("tready timeout", 64'd0, 64'd1);
        done = 1;
      end else begin
        waited++;
        @(negedge clock);
      end
    end
    lastWaited = waited;
  endtask

  task automatic idleCycle();
    @(negedge clock);
    tvalid = 1'b0;
    tstrb  = 1'b0;
    tlast  = 1'b0;
    #4;
  endtask

  task automatic waitBeats(input int target);
    int n = 0;
    idleCycle();
    #2;
    while (beatCount < target && n < 100) begin
      @(negedge clock);
      #6;
      n++;
    end
    checkOutput("beat count", beatCount, target);
  endtask

  // Every handshaken beat must be the next one the model predicted; a stalled
  // beat must not change while it waits.
  initial begin
    beat_t e;
    beat_t cur;
    logic [SW-1:0] byteMask;
    prevStall = 0;
    forever begin
      @(negedge clock);
      #4;
      cur.addr = waddr;
      cur.data = wdata;
      cur.strb = wstrb;
      cur.last = wlast;
      if (reset !== 1'b0) begin
        prevStall = 0;
      end else begin
        if (prevStall) begin
          checkOutput("hold wvalid", wvalid, 1);
          checkOutput("hold waddr", waddr, prevOut.addr);
          checkOutput("hold wdata", wdata, prevOut.data);
          checkOutput("hold wstrb", wstrb, prevOut.strb);
          checkOutput("hold wlast", wlast, prevOut.last);
        end
        if (wvalid === 1'b1 && wready === 1'b1) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected beat", 64'd1, 64'd0);
          end else begin
            e = expQ.pop_front();
            byteMask = {{8{e.strb[3]}}, {8{e.strb[2]}}, {8{e.strb[1]}}, {8{e.strb[0]}}};
            checkOutput("beat waddr", waddr, e.addr);
            checkOutput("beat wstrb", wstrb, e.strb);
            checkOutput("beat wlast", wlast, e.last);
            checkOutput("beat wdata", wdata & byteMask, e.data & byteMask);
          end
          beatCount++;
          lastBeat = cur;
        end
        prevStall = (wvalid === 1'b1) && (wready !== 1'b1);
        prevOut   = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    tvalid = 1'b0;
    tdata  = '0;
    tdest  = '0;
    tstrb  = 1'b0;
    tlast  = 1'b0;
    wready = 1'b1;
    mValid = 0;
    #4;
    checkOutput("reset tready", tready, 1);
    checkOutput("reset wvalid", wvalid, 0);
    checkOutput("reset wlast", wlast, 0);
    checkOutput("reset wstrb", wstrb, 0);
    checkOutput("reset wdata", wdata, 0);
    checkOutput("reset waddr", waddr, 0);
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] full word then tag change");
    applyStimulus(32'd0, 16'h1111, 1, 0);
    applyStimulus(32'd1, 16'h2222, 1, 0);
    applyStimulus(32'd2, 16'h3333, 1, 0);
    checkOutput("model word0 data", expQ[expQ.size()-1].data, 32'h22221111);
    idleCycle();
    checkOutput("tag change wvalid", wvalid, 1);
    checkOutput("word0 waddr", waddr, 0);
    checkOutput("word0 wdata", wdata, 32'h22221111);
    checkOutput("word0 wstrb", wstrb, 4'hF);
    checkOutput("word0 wlast", wlast, 0);

    $display("[TB] partial word closed by tlast");
    applyStimulus(32'd4, 16'hAAAA, 1, 0);
    applyStimulus(32'd5, 16'h0000, 0, 1);
    idleCycle();
    checkOutput("tlast N+1 wvalid", wvalid, 0);
    idleCycle();
    checkOutput("tlast N+2 wvalid", wvalid, 1);
    checkOutput("tlast wlast", wlast, 1);
    checkOutput("tlast waddr", waddr, 2);
    checkOutput("tlast wdata lo", wdata[15:0], 16'hAAAA);
    checkOutput("tlast wstrb", wstrb, 4'h3);
    waitBeats(3);

    $display("[TB] zero-mask word dropped");
    applyStimulus(32'd8, 16'h5555, 0, 0);
    applyStimulus(32'd9, 16'h6666, 0, 0);
    applyStimulus(32'd10, 16'hBEEF, 1, 1);
    idleCycle();
    checkOutput("dropped word wvalid", wvalid, 0);
    waitBeats(4);
    checkOutput("after drop waddr", lastBeat.addr, 5);
    checkOutput("after drop wdata lo", lastBeat.data[15:0], 16'hBEEF);
    repeat (3) idleCycle();
    checkOutput("no beat for waddr 4", beatCount, 4);

    $display("[TB] backpressure across three words");
    fork
      begin
        @(negedge clock);
        wready = 1'b0;
        repeat (5) @(negedge clock);
        wready = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++) begin
          applyStimulus(32'(12 + i), 16'h1200 + 16'(12 + i), 1, (i == 5));
          waitedArr[i] = lastWaited;
        end
      end
    join
    checkOutput("first tag change not stalled", waitedArr[2], 0);
    checkOutput("merge under stall not stalled", waitedArr[3], 0);
    checkOutput("tready drop on second tag change", waitedArr[4] > 0, 1);
    waitBeats(7);
    checkOutput("bp last waddr", lastBeat.addr, 8);
    checkOutput("bp last wdata", lastBeat.data, 32'h12111210);
    checkOutput("bp last wlast", lastBeat.last, 1);

    $display("[TB] same lane overwrite");
    applyStimulus(32'd6, 16'h1234, 1, 0);
    applyStimulus(32'd6, 16'h5678, 1, 0);
    applyStimulus(32'd7, 16'h0000, 0, 1);
    waitBeats(8);
    checkOutput("overwrite wdata lo", lastBeat.data[15:0], 16'h5678);
    checkOutput("overwrite wstrb", lastBeat.strb, 4'h3);
    checkOutput("overwrite waddr", lastBeat.addr, 3);

    $display("[TB] reset mid-accumulation");
    applyStimulus(32'd20, 16'h0BAD, 1, 0);
    @(negedge clock);
    tvalid = 1'b0;
    reset  = 1'b1;
    #4;
    checkOutput("mid reset wvalid", wvalid, 0);
    checkOutput("mid reset tready", tready, 1);
    expQ.delete();
    mValid = 0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("post reset wvalid", wvalid, 0);
    end
    applyStimulus(32'd20, 16'hC0DE, 1, 0);
    applyStimulus(32'd21, 16'hFACE, 1, 1);
    waitBeats(9);
    checkOutput("fresh wdata", lastBeat.data, 32'hFACEC0DE);
    checkOutput("fresh wstrb", lastBeat.strb, 4'hF);
    checkOutput("fresh waddr", lastBeat.addr, 10);
    checkOutput("fresh wlast", lastBeat.last, 1);

    repeat (3) idleCycle();
    checkOutput("model queue drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
